// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int MAX_BURST_DEF  = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } resp_owner_t;

   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, load/store and memory-macro signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int BEW = DATA_WIDTH / 8;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_err;

   logic                  d_req;
   logic                  d_we;
   logic [BEW-1:0]        d_be;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [BEW-1:0]        mem_be;
   logic [ADDR_WIDTH-3:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/unified_mem_arbiter_prio.sv
// Grant decision: data wins unless fetch has waited MAX_BURST data grants.
module unified_mem_arbiter_prio #(
   parameter int MAX_BURST = 4,
   parameter int CW        = $clog2(MAX_BURST + 1)
) (
   input  logic          if_req_i,
   input  logic          d_req_i,
   input  logic [CW-1:0] burst_q_i,
   output logic          if_gnt_o,
   output logic          d_gnt_o,
   output logic [CW-1:0] burst_d_o
);

   logic cap;

   always_comb begin
      cap       = (burst_q_i == CW'(MAX_BURST));
      d_gnt_o   = d_req_i & ~(if_req_i & cap);
      if_gnt_o  = if_req_i & ~d_gnt_o;
      burst_d_o = '0;
      // Count only data grants that make fetch wait
      if (d_gnt_o && if_req_i) begin
         burst_d_o = cap ? burst_q_i : burst_q_i + CW'(1);
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory shared by fetch and load/store ports.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input  logic clk,
   input  logic res,
   unified_mem_arbiter_if.slave bus
);

   localparam int BEW = DATA_WIDTH / 8;
   localparam int CW  = cnt_width(MAX_BURST);

   logic [CW-1:0] burst_q, burst_d;
   resp_owner_t   owner_q, owner_d;
   logic          err_q, err_d;
   logic          if_gnt, d_gnt;

   unified_mem_arbiter_prio #(
      .MAX_BURST (MAX_BURST),
      .CW        (CW)
   ) u_prio (
      .if_req_i  (bus.if_req),
      .d_req_i   (bus.d_req),
      .burst_q_i (burst_q),
      .if_gnt_o  (if_gnt),
      .d_gnt_o   (d_gnt),
      .burst_d_o (burst_d)
   );

   assign bus.if_gnt = if_gnt;
   assign bus.d_gnt  = d_gnt;

   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (1'b1)
         if_gnt: begin
            bus.mem_req  = 1'b1;
            bus.mem_be   = '1;
            bus.mem_addr = bus.if_addr[ADDR_WIDTH-1:2];
         end
         d_gnt: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_be;
            bus.mem_addr  = bus.d_addr[ADDR_WIDTH-1:2];
            bus.mem_wdata = bus.d_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      owner_d = OWN_NONE;
      err_d   = 1'b0;
      unique case (1'b1)
         if_gnt: begin
            owner_d = OWN_IF;
            err_d   = (bus.if_addr[1:0] != 2'b00);
         end
         d_gnt: begin
            owner_d = bus.d_we ? OWN_NONE : OWN_D;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         burst_q <= '0;
         owner_q <= OWN_NONE;
         err_q   <= 1'b0;
      end else begin
         burst_q <= burst_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      bus.if_rvalid = (owner_q == OWN_IF);
      bus.d_rvalid  = (owner_q == OWN_D);
      bus.if_err    = bus.if_rvalid & err_q;
      bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
      bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
   end

   // Data accesses are word-aligned by the core; low bits are ignored
   logic unused_d_addr;
   assign unused_d_addr = ^bus.d_addr[1:0];

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for the unified memory arbiter with a small memory model.
module tb_unified_mem_arbiter;

   logic clk = 1'b0;
   logic res;

   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   unified_mem_arbiter #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .MAX_BURST  (4)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   logic [31:0] mem [64];
   logic [31:0] rdata_q;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
   end

   always @(posedge clk) begin
      if (bus.mem_req && !bus.mem_we) rdata_q <= mem[bus.mem_addr];
      if (bus.mem_req && bus.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
   end

   assign bus.mem_rdata = rdata_q;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   logic [1:0] exp_g, prev_g;

   initial begin
      res         = 1'b1;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_be    = '0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("rst_if_err", 32'(bus.if_err), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
      chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
      res = 1'b0;

      // Uncontended fetch
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h10;
      #1;
      chk("f_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'b10);
      chk("f_mem_addr", 32'(bus.mem_addr), 32'h04);
      chk("f_mem_we", 32'(bus.mem_we), 32'd0);
      chk("f_mem_be", 32'(bus.mem_be), 32'hF);
      @(negedge clk);
      bus.if_req = 1'b0;
      #1;
      chk("f_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("f_rdata", bus.if_rdata, 32'hA000_0004);
      chk("f_err", 32'(bus.if_err), 32'd0);
      chk("f_mem_req_idle", 32'(bus.mem_req), 32'd0);

      // Contended: data load wins, fetch follows when data drops
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h14;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h20;
      #1;
      chk("c_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'b01);
      chk("c_mem_addr", 32'(bus.mem_addr), 32'h08);
      @(negedge clk);
      bus.d_req = 1'b0;
      #1;
      chk("c_d_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("c_d_rdata", bus.d_rdata, 32'hA000_0008);
      chk("c_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("c_gnts2", 32'({bus.if_gnt, bus.d_gnt}), 32'b10);
      chk("c_mem_addr2", 32'(bus.mem_addr), 32'h05);
      @(negedge clk);
      bus.if_req = 1'b0;
      #1;
      chk("c_if_rdata", bus.if_rdata, 32'hA000_0005);
      chk("c_d_rvalid2", 32'(bus.d_rvalid), 32'd0);

      // Starvation bound with continuous data traffic
      prev_g = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b0;
            bus.d_addr  = 8'h20;
            bus.if_req  = 1'b1;
            bus.if_addr = 8'h18;
         end
         #1;
         exp_g = (i == 4 || i == 9) ? 2'b10 : 2'b01;
         if (i > 0) chk("b_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'(prev_g));
         chk("b_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'(exp_g));
         prev_g = exp_g;
      end
      @(negedge clk);
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      #1;
      chk("b_last_rv", 32'({bus.if_rvalid, bus.d_rvalid}), 32'b10);
      chk("b_last_rdata", bus.if_rdata, 32'hA000_0006);

      // Byte-enabled store
      @(negedge clk);
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_be    = 4'b0011;
      bus.d_addr  = 8'h08;
      bus.d_wdata = 32'hDEAD_BEEF;
      #1;
      chk("s_gnt", 32'(bus.d_gnt), 32'd1);
      chk("s_mem_we", 32'(bus.mem_we), 32'd1);
      chk("s_mem_be", 32'(bus.mem_be), 32'b0011);
      chk("s_mem_addr", 32'(bus.mem_addr), 32'h02);
      chk("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      bus.d_we = 1'b0;
      bus.d_be = 4'b0000;
      #1;
      chk("s_no_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("s_rd_we", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      bus.d_req = 1'b0;
      #1;
      chk("s_readback", bus.d_rdata, 32'hA000_BEEF);

      // Misaligned fetch
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h06;
      #1;
      chk("m_mem_addr", 32'(bus.mem_addr), 32'h01);
      @(negedge clk);
      bus.if_req = 1'b0;
      #1;
      chk("m_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("m_err", 32'(bus.if_err), 32'd1);
      chk("m_rdata", bus.if_rdata, 32'hA000_0001);

      // Reset while burst count is nonzero and a load is in flight
      @(negedge clk);
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h20;
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h10;
      #1;
      chk("r_pre_g0", 32'({bus.if_gnt, bus.d_gnt}), 32'b01);
      @(negedge clk);
      #1;
      chk("r_pre_g1", 32'({bus.if_gnt, bus.d_gnt}), 32'b01);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      #1;
      chk("r_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'b00);
      chk("r_rdata", bus.d_rdata, 32'd0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         exp_g = (i == 4) ? 2'b10 : 2'b01;
         chk("r_post_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'(exp_g));
      end

      // Reset during a fetch read
      @(negedge clk);
      bus.d_req  = 1'b0;
      bus.if_req = 1'b1;
      res        = 1'b1;
      #1;
      chk("r2_prev_rv", 32'(bus.if_rvalid), 32'd1);
      @(negedge clk);
      res        = 1'b0;
      bus.if_req = 1'b0;
      #1;
      chk("r2_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("r2_rdata", bus.if_rdata, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, byte-enabled unified memory between the instruction-fetch port and the load/store port of the riscv_32i core, so programs and data can live in one memory image. Grants at most one access per cycle, returns read data one cycle after the grant, and bounds data-side priority so fetch cannot starve. Sits between the core's fetch/data interfaces and the memory macro; the core stalls on a missing grant.

## Interface
- ADDR_WIDTH, 8, byte-address width of both requester ports
- DATA_WIDTH, 32, word width; byte enables are DATA_WIDTH/8 bits
- MAX_BURST, 4, max consecutive data grants while fetch waits (≥1)

- clk  in  1  clock; all state on rising edge
- res  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until granted
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DATA_WIDTH  fetch data
- if_err  out  1  with if_rvalid: granted address was misaligned
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_WIDTH/8  store byte enables
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered; never for stores)
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH-2  word address (byte address >> 2)
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read mem_req

## Operation
- Grant decision combinational from d_req, if_req, burst_cnt; exactly one of if_gnt/d_gnt or neither.
- Only d_req: grant data. Only if_req: grant fetch. Neither: mem_req=0.
- Both: grant data unless burst_cnt == MAX_BURST, then grant fetch.
- burst_cnt (saturating, $clog2(MAX_BURST+1) bits): +1 on data grant while if_req=1; cleared on fetch grant or if_req=0.
- Memory mux follows the grant: fetch → mem_we=0, mem_be=all ones; data → d_we/d_be/d_wdata passed through.
- Fetch-granted reads force mem_we=0 regardless of d_we.
- resp_owner register: {NONE, IF, D}; loaded each cycle with owner of a granted read (store → NONE).
- resp_owner IF → if_rvalid=1, if_rdata=mem_rdata, if_err=registered (if_addr[1:0]!=0). D → d_rvalid=1, d_rdata=mem_rdata.
- rdata outputs are 0 when matching rvalid is 0.
- Misaligned data addresses: low bits dropped, no error (core aligns loads/stores).

## Timing
- Reset: burst_cnt=0, resp_owner=NONE; all registered outputs (if_rvalid, d_rvalid, if_err) 0; with requests low all outputs 0.
- Reset asserted while a read is in flight: response dropped, no rvalid next cycle.
- Read latency: grant in cycle N → rvalid in N+1; back-to-back grants give back-to-back rvalids.
- Store completes at grant cycle; no response.
- Requests granted the cycle they are presented if arbitration allows; zero-cycle wait when uncontended.
- Requester may change address only after its gnt.
- Fetch worst-case wait under continuous data traffic: MAX_BURST cycles.

## Structure
- Shared package risc_pkg: resp_owner_t enum {OWN_NONE, OWN_IF, OWN_D}; MAX_BURST default constant.
- One sub-module natural: mem_arb_prio (combinational grant + burst_cnt compare), instantiated once.
- Datapath mux reuses ../mux.v.

## Test plan
- Uncontended fetch: if_req=1, if_addr=0x10 → if_gnt same cycle, mem_addr=0x04, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
- Contended: both requesting, d_we=0, d_addr=0x20 → d_gnt=1, if_gnt=0; next cycle d_rvalid=1, if_rvalid=0; fetch granted following cycle if d_req drops.
- Starvation bound: d_req and if_req held 10 cycles, MAX_BURST=4 → grants D,D,D,D,IF,D,D,D,D,IF.
- Store: d_we=1, d_be=4'b0011, d_addr=0x08, d_wdata=0xDEADBEEF → mem_we=1, mem_be=0011, mem_addr=0x02; no d_rvalid next cycle.
- Misaligned fetch if_addr=0x06 → mem_addr=0x01, next cycle if_rvalid=1, if_err=1.
- Reset mid-read: grant fetch in cycle N, res=1 in N → cycle N+1 if_rvalid=0, burst_cnt=0.
